// File: rtl/mmio_bridge.sv
// CPU-to-peripheral MMIO bridge: decodes the CPU data access into a one-hot slot
// select, runs one access window on the shared io_* bus and stalls the CPU until done.

module mmio_bridge_slot #(
   parameter logic [3:0] IDX = 4'd0
) (
   input  logic        active,
   input  logic        hit,
   input  logic [3:0]  slot,
   input  logic [31:0] rdata,
   output logic        sel,
   output logic [31:0] rd_gated
);
   logic match;

   assign match    = hit && (slot == IDX);
   assign sel      = active && match;
   // Non-selected slots contribute zero so the top can OR-reduce the lanes.
   assign rd_gated = match ? rdata : '0;
endmodule

module mmio_bridge #(
   parameter int          NSLV    = 4,
   parameter logic [15:0] BASE_HI = 16'h1000,
   parameter int          WAIT    = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [31:0]        cpu_addr,
   input  logic [3:0]         cpu_mask,
   input  logic [31:0]        cpu_wdata,
   output logic [31:0]        cpu_rdata,
   output logic               cpu_stall,
   output logic               bus_err,
   output logic [31:0]        io_addr,
   output logic               io_op,
   output logic [3:0]         io_mask,
   output logic [31:0]        io_wdata,
   output logic [NSLV-1:0]    io_sel,
   input  logic [32*NSLV-1:0] io_rdata_bus
);
   localparam logic [3:0] WAIT_W = 4'(WAIT);
   localparam logic [4:0] NSLV_W = 5'(NSLV);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t state, state_nx;

   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  mask_q, slot_q, cnt;
   logic        we_q, hit_q;
   logic        hit, access;

   logic [NSLV-1:0][31:0] rd_lane;
   logic [31:0]           rd_or;

   assign hit = (cpu_addr[31:16] == BASE_HI) && ({1'b0, cpu_addr[15:12]} < NSLV_W);

   for (genvar k = 0; k < NSLV; k++) begin : g_slot
      mmio_bridge_slot #(.IDX(4'(k))) u_slot (
         .active   (access),
         .hit      (hit_q),
         .slot     (slot_q),
         .rdata    (io_rdata_bus[32*k +: 32]),
         .sel      (io_sel[k]),
         .rd_gated (rd_lane[k])
      );
   end

   always_comb begin
      rd_or = '0;
      for (int k = 0; k < NSLV; k++) rd_or |= rd_lane[k];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (cpu_req) state_nx = ACCESS;
         ACCESS:  if (cnt == '0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The counter starts at WAIT, so cnt == WAIT marks the first ACCESS cycle and
   // gives exactly one write strobe per store.
   always_comb begin
      cpu_stall = 1'b0;
      io_op     = 1'b0;
      bus_err   = 1'b0;
      cpu_rdata = '0;
      access    = 1'b0;
      unique case (state)
         IDLE:   cpu_stall = cpu_req;
         ACCESS: begin
            cpu_stall = 1'b1;
            access    = 1'b1;
            io_op     = we_q && hit_q && (cnt == WAIT_W);
         end
         DONE: begin
            cpu_rdata = rdata_q;
            bus_err   = !hit_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         we_q    <= 1'b0;
         hit_q   <= 1'b0;
         slot_q  <= '0;
         cnt     <= '0;
         rdata_q <= '0;
      end else begin
         unique case (state)
            IDLE: if (cpu_req) begin
               addr_q  <= cpu_addr;
               wdata_q <= cpu_wdata;
               mask_q  <= cpu_mask;
               we_q    <= cpu_we;
               hit_q   <= hit;
               slot_q  <= cpu_addr[15:12];
               cnt     <= WAIT_W;
            end
            ACCESS: begin
               if (cnt == '0) rdata_q <= we_q ? '0 : rd_or;
               else           cnt     <= cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign io_addr  = addr_q;
   assign io_mask  = mask_q;
   assign io_wdata = wdata_q;
endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: two instances (WAIT=0 and WAIT=3) checked every cycle
// against a transaction-timeline model, plus directed literal checks.
module tb_mmio_bridge;
   localparam int NS = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req[2], we[2];
   logic [31:0] addr[2], wd[2];
   logic [3:0]  mask[2];
   logic [32*NS-1:0] bus;

   logic [31:0] rdata[2], io_addr[2], io_wdata[2];
   logic        stall[2], err[2], op[2];
   logic [3:0]  io_mask[2];
   logic [NS-1:0] sel[2];

   mmio_bridge #(.NSLV(NS), .BASE_HI(16'h1000), .WAIT(0)) u0 (
      .clk(clk), .rst(rst), .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]),
      .cpu_mask(mask[0]), .cpu_wdata(wd[0]), .cpu_rdata(rdata[0]), .cpu_stall(stall[0]),
      .bus_err(err[0]), .io_addr(io_addr[0]), .io_op(op[0]), .io_mask(io_mask[0]),
      .io_wdata(io_wdata[0]), .io_sel(sel[0]), .io_rdata_bus(bus));

   mmio_bridge #(.NSLV(NS), .BASE_HI(16'h1000), .WAIT(3)) u1 (
      .clk(clk), .rst(rst), .cpu_req(req[1]), .cpu_we(we[1]), .cpu_addr(addr[1]),
      .cpu_mask(mask[1]), .cpu_wdata(wd[1]), .cpu_rdata(rdata[1]), .cpu_stall(stall[1]),
      .bus_err(err[1]), .io_addr(io_addr[1]), .io_op(op[1]), .io_mask(io_mask[1]),
      .io_wdata(io_wdata[1]), .io_sel(sel[1]), .io_rdata_bus(bus));

   int nchk = 0, npass = 0;

   task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
      nchk++;
      if (a !== e) $display("FAIL %s dut%0d got %h want %h at %0t", nm, d, a, e, $time);
      else npass++;
   endtask

   function automatic int wt(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   // Model: each accepted request has a timeline relative to its accept cycle t0:
   // ACCESS in t0+1..t0+W+1, DONE in t0+W+2, idle afterwards.
   bit          act[2];
   int          t0[2];
   logic        m_we[2], m_hit[2];
   logic [3:0]  m_slot[2], m_mask[2];
   logic [31:0] m_addr[2], m_wd[2], m_rd[2];
   int          cyc = 0;

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         act[d] = 0; t0[d] = 0; m_we[d] = 0; m_hit[d] = 0; m_slot[d] = 0;
         m_mask[d] = 0; m_addr[d] = 0; m_wd[d] = 0; m_rd[d] = 0;
      end
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            if (act[d] && cyc == t0[d] + wt(d) + 1)
               m_rd[d] = (m_hit[d] && !m_we[d]) ? bus[32*m_slot[d] +: 32] : 32'h0;
            if ((!act[d] || cyc > t0[d] + wt(d) + 2) && req[d]) begin
               act[d]    = 1;
               t0[d]     = cyc;
               m_we[d]   = we[d];
               m_hit[d]  = (addr[d][31:16] == 16'h1000) && (int'(addr[d][15:12]) < NS);
               m_slot[d] = addr[d][15:12];
               m_addr[d] = addr[d];
               m_mask[d] = mask[d];
               m_wd[d]   = wd[d];
            end
         end
      end
      cyc++;
   end

   always @(negedge rst) model_clear();

   always @(negedge clk) begin
      int rel;
      bit inacc, done;
      logic [NS-1:0] e_sel;
      for (int d = 0; d < 2; d++) begin
         rel   = cyc - t0[d];
         inacc = act[d] && rel >= 1 && rel <= wt(d) + 1;
         done  = act[d] && rel == wt(d) + 2;
         e_sel = (inacc && m_hit[d]) ? NS'(1 << m_slot[d]) : '0;
         chk("stall",  d, stall[d], inacc ? 1'b1 : done ? 1'b0 : req[d]);
         chk("io_sel", d, sel[d], e_sel);
         chk("io_op",  d, op[d], inacc && rel == 1 && m_we[d] && m_hit[d]);
         chk("bus_err", d, err[d], done && !m_hit[d]);
         chk("rdata",  d, rdata[d], done ? m_rd[d] : 32'h0);
         chk("io_addr", d, io_addr[d], m_addr[d]);
         chk("io_mask", d, io_mask[d], m_mask[d]);
         chk("io_wdata", d, io_wdata[d], m_wd[d]);
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask
   task automatic neg(); @(negedge clk); endtask
   task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] v);
      req[d] = r; we[d] = w; addr[d] = a; mask[d] = m; wd[d] = v;
   endtask

   initial begin
      int nop, nsel;
      model_clear();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) drive(d, 0, 0, 0, 0, 0);
      bus = {32'h3333_4444, 32'hDEAD_BEEF, 32'h1111_2222, 32'h0A0A_0A0A};
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      // store hit, WAIT=0
      tick; drive(0, 1, 1, 32'h1000_0004, 4'hF, 32'h3);
      neg; chk("t1_stall_c0", 0, stall[0], 1); chk("t1_sel_c0", 0, sel[0], 0);
      tick; neg; chk("t1_sel_c1", 0, sel[0], 4'b0001); chk("t1_op_c1", 0, op[0], 1);
      chk("t1_wdata", 0, io_wdata[0], 32'h3);
      tick; req[0] = 0; neg; chk("t1_stall_c2", 0, stall[0], 0); chk("t1_op_c2", 0, op[0], 0);
      chk("t1_err", 0, err[0], 0);
      tick;

      // load hit slot 2
      drive(0, 1, 0, 32'h1000_2000, 4'hF, 32'h0);
      tick; neg; chk("t2_op", 0, op[0], 0); chk("t2_sel", 0, sel[0], 4'b0100);
      tick; req[0] = 0; neg; chk("t2_rdata", 0, rdata[0], 32'hDEAD_BEEF);
      chk("t2_stall", 0, stall[0], 0);
      tick;

      // unmapped load, then store to slot 7 with NSLV=4
      drive(0, 1, 0, 32'h2000_0000, 4'hF, 32'h0);
      tick; neg; chk("t3a_sel", 0, sel[0], 0);
      tick; req[0] = 0; neg; chk("t3a_err", 0, err[0], 1); chk("t3a_rdata", 0, rdata[0], 0);
      tick; drive(0, 1, 1, 32'h1000_7000, 4'h3, 32'h55);
      tick; neg; chk("t3b_sel", 0, sel[0], 0); chk("t3b_op", 0, op[0], 0);
      tick; req[0] = 0; neg; chk("t3b_err", 0, err[0], 1);
      tick; neg; chk("t3b_err_pulse", 0, err[0], 0);

      // back-to-back: store slot 0 held through DONE, then load slot 1
      drive(0, 1, 1, 32'h1000_0000, 4'hF, 32'h5);
      tick; tick;
      tick; drive(0, 1, 0, 32'h1000_1004, 4'hF, 32'h0);
      neg; chk("t5_no_reaccept_op", 0, op[0], 0); chk("t5_no_reaccept_sel", 0, sel[0], 0);
      tick; neg; chk("t5_sel2", 0, sel[0], 4'b0010); chk("t5_addr2", 0, io_addr[0], 32'h1000_1004);
      tick; req[0] = 0; neg; chk("t5_rdata2", 0, rdata[0], 32'h1111_2222);
      tick;

      // input churn mid-ACCESS
      drive(0, 1, 0, 32'h1000_3010, 4'hF, 32'h0);
      tick; drive(0, 0, 1, 32'h1000_1000, 4'h0, 32'hFFFF);
      neg; chk("t5c_addr", 0, io_addr[0], 32'h1000_3010); chk("t5c_sel", 0, sel[0], 4'b1000);
      chk("t5c_op", 0, op[0], 0); chk("t5c_mask", 0, io_mask[0], 4'hF);
      tick; neg; chk("t5c_rdata", 0, rdata[0], 32'h3333_4444);
      tick;

      // WAIT=3 store on the second instance
      drive(1, 1, 1, 32'h1000_1008, 4'h3, 32'hABCD);
      neg; chk("t4_stall_c0", 1, stall[1], 1);
      nop = 0; nsel = 0;
      for (int i = 1; i <= 5; i++) begin
         tick;
         if (i == 1) req[1] = 0;
         neg;
         if (i <= 4) begin
            nop += int'(op[1]);
            nsel += int'(sel[1] == 4'b0010);
            chk("t4_stall_acc", 1, stall[1], 1);
         end
      end
      chk("t4_op_count", 1, nop, 1); chk("t4_sel_count", 1, nsel, 4);
      chk("t4_done_stall", 1, stall[1], 0); chk("t4_wdata", 1, io_wdata[1], 32'hABCD);
      tick;

      // async reset in the middle of a store's ACCESS
      drive(0, 1, 1, 32'h1000_2000, 4'hF, 32'h77);
      tick; #2 rst = 1'b0; #1;
      chk("t6_op_rst", 0, op[0], 0); chk("t6_sel_rst", 0, sel[0], 0);
      chk("t6_stall_rst", 0, stall[0], 1); chk("t6_addr_rst", 0, io_addr[0], 0);
      req[0] = 0;
      tick; #2 rst = 1'b1;
      nop = 0;
      repeat (4) begin tick; neg; nop += int'(op[0]); end
      chk("t6_no_strobe", 0, nop, 0); chk("t6_addr_after", 0, io_addr[0], 0);
      tick;

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
